// File: rtl/spi_px_master.sv
// SPI initiator (mode 0) that sends one pixel per CS frame and returns the
// word shifted in from the target during that frame.
module spi_px_master #(
    parameter int PX_BITS = 24,
    parameter int CLK_DIV = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [PX_BITS-1:0] tx_data_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    output logic [PX_BITS-1:0] rx_data_o,
    output logic               rx_valid_o,
    output logic               busy_o,
    output logic               spi_cs_o,
    output logic               spi_sck_o,
    output logic               spi_sdo_o,
    input  logic               spi_sdi_i
);

    localparam int CNT_W = $clog2(PX_BITS + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PX_BITS);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [PX_BITS-1:0] r_tx_sr;
    logic [PX_BITS-1:0] r_rx_sr;
    logic [PX_BITS-1:0] r_rx_data;
    logic               r_rx_valid;
    logic               r_cs;
    logic               r_sck;
    logic               r_sdo;

    logic               w_div_done;

    // Terminal count of the shared half-period / phase-length divider
    assign w_div_done = (r_div == DIV_LAST);

    // Frame sequencer: phase timing, SCK generation, TX/RX shifting
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= StIdle;
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_cs       <= 1'b1;
            r_sck      <= 1'b0;
            r_sdo      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (tx_valid_i) begin
                        r_tx_sr   <= tx_data_i;
                        r_rx_sr   <= '0;
                        r_bit_cnt <= '0;
                        r_div     <= '0;
                        r_cs      <= 1'b0;
                        r_sdo     <= tx_data_i[PX_BITS-1];
                        r_state   <= StSetup;
                    end
                end
                StSetup: begin
                    r_sdo <= r_tx_sr[PX_BITS-1];
                    if (w_div_done) begin
                        // First SCK rise: sample the first target bit
                        r_div     <= '0;
                        r_sck     <= 1'b1;
                        r_rx_sr   <= {r_rx_sr[PX_BITS-2:0], spi_sdi_i};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_state   <= StShift;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                StShift: begin
                    if (w_div_done) begin
                        r_div <= '0;
                        if (r_sck) begin
                            // Falling edge: present next bit, or park SDO low after the last one
                            r_sck   <= 1'b0;
                            r_tx_sr <= {r_tx_sr[PX_BITS-2:0], 1'b0};
                            r_sdo   <= (r_bit_cnt == CNT_LAST) ? 1'b0 : r_tx_sr[PX_BITS-2];
                        end else if (r_bit_cnt == CNT_LAST) begin
                            // Low half-period after the final fall has elapsed
                            r_state <= StHold;
                        end else begin
                            r_sck     <= 1'b1;
                            r_rx_sr   <= {r_rx_sr[PX_BITS-2:0], spi_sdi_i};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                StHold: begin
                    if (w_div_done) begin
                        r_div      <= '0;
                        r_cs       <= 1'b1;
                        r_rx_data  <= r_rx_sr;
                        r_rx_valid <= 1'b1;
                        r_state    <= StGap;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                StGap: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign tx_ready_o = (r_state == StIdle);
    assign busy_o     = (r_state != StIdle);
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign spi_cs_o   = r_cs;
    assign spi_sck_o  = r_sck;
    assign spi_sdo_o  = r_sdo;

endmodule

// File: tb/tb_spi_px_master.sv
// Bench for spi_px_master: frame-level model plus directed literal checks.
module tb_spi_px_master;

    localparam int PX     = 8;
    localparam int CD     = 2;
    localparam int FRAME  = (2 * PX + 3) * CD;
    localparam int CSLAST = (2 * PX + 2) * CD;
    localparam int RXV    = CSLAST + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: PX_BITS=8, CLK_DIV=2
    logic [7:0]  tx_data_a;
    logic        tx_valid_a, tx_ready_a, rx_valid_a, busy_a;
    logic [7:0]  rx_data_a;
    logic        cs_a, sck_a, sdo_a, sdi_a;

    // DUT B: PX_BITS=24, CLK_DIV=1, loopback
    logic [23:0] tx_data_b;
    logic        tx_valid_b, tx_ready_b, rx_valid_b, busy_b;
    logic [23:0] rx_data_b;
    logic        cs_b, sck_b, sdo_b;

    spi_px_master #(.PX_BITS(PX), .CLK_DIV(CD)) u_dut_a (
        .clk_i      (clk),
        .reset_i    (rst),
        .tx_data_i  (tx_data_a),
        .tx_valid_i (tx_valid_a),
        .tx_ready_o (tx_ready_a),
        .rx_data_o  (rx_data_a),
        .rx_valid_o (rx_valid_a),
        .busy_o     (busy_a),
        .spi_cs_o   (cs_a),
        .spi_sck_o  (sck_a),
        .spi_sdo_o  (sdo_a),
        .spi_sdi_i  (sdi_a)
    );

    spi_px_master #(.PX_BITS(24), .CLK_DIV(1)) u_dut_b (
        .clk_i      (clk),
        .reset_i    (rst),
        .tx_data_i  (tx_data_b),
        .tx_valid_i (tx_valid_b),
        .tx_ready_o (tx_ready_b),
        .rx_data_o  (rx_data_b),
        .rx_valid_o (rx_valid_b),
        .busy_o     (busy_b),
        .spi_cs_o   (cs_b),
        .spi_sck_o  (sck_b),
        .spi_sdo_o  (sdo_b),
        .spi_sdi_i  (sdo_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Target model for DUT A: loopback, or a fixed word shifted out on SCK falls
    logic       sdi_fixed;
    logic [7:0] fixed_word;
    int         tgt_n = 0;
    logic       tgt_bit;
    always @(negedge cs_a) tgt_n = 0;
    always @(negedge sck_a) tgt_n = tgt_n + 1;
    assign tgt_bit = (tgt_n < 8) ? fixed_word[7 - tgt_n] : 1'b0;
    assign sdi_a   = sdi_fixed ? tgt_bit : sdo_a;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Frame-level model: m_c is the 1-based cycle index within the current frame
    bit         m_active = 1'b0;
    bit         m_idle_before;
    int         m_c = 0;
    int         m_frames = 0;
    logic [7:0] m_data = '0;
    logic [7:0] m_exp = '0;
    logic [7:0] m_rxd = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_c      = 0;
            m_rxd    = '0;
        end else begin
            m_idle_before = !m_active;
            if (m_active) begin
                m_c = m_c + 1;
                if (m_c > FRAME) m_active = 1'b0;
            end
            if (m_idle_before && tx_valid_a) begin
                m_active = 1'b1;
                m_c      = 1;
                m_data   = tx_data_a;
                m_exp    = sdi_fixed ? fixed_word : tx_data_a;
                m_frames = m_frames + 1;
            end
            if (m_active && m_c == RXV) m_rxd = m_exp;
        end
    end

    // Compare DUT A against the model every cycle
    bit   chk_en = 1'b0;
    logic e_cs, e_sck, e_sdo, e_busy, e_rdy, e_rxv;
    int   e_s;
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            e_cs = 1'b1; e_sck = 1'b0; e_sdo = 1'b0; e_busy = 1'b0; e_rdy = 1'b1; e_rxv = 1'b0;
            if (m_active) begin
                e_busy = 1'b1;
                e_rdy  = 1'b0;
                e_cs   = (m_c <= CSLAST) ? 1'b0 : 1'b1;
                e_rxv  = (m_c == RXV);
                e_s    = m_c - 1 - CD;
                e_sck  = (e_s >= 0) && (e_s < 2 * PX * CD) && (((e_s / CD) % 2) == 0);
                e_sdo  = (m_c <= 2 * PX * CD) ? m_data[PX - 1 - ((m_c - 1) / (2 * CD))] : 1'b0;
            end
            chk("cs", cs_a, e_cs);
            chk("sck", sck_a, e_sck);
            chk("sdo", sdo_a, e_sdo);
            chk("busy", busy_a, e_busy);
            chk("tx_ready", tx_ready_a, e_rdy);
            chk("rx_valid", rx_valid_a, e_rxv);
            chk("rx_data", rx_data_a, m_rxd);
        end
    end

    // Observer of DUT A pins for the hand-computed frame checks
    int         ob_t0 = 0, ob_prev_t0 = 0, ob_rises = 0, ob_first_rise = 0, ob_rxv_c = 0;
    int         ob_cs_low = 0, ob_high_run = 0, ob_gap = 0, ob_frames = 0, ob_c;
    logic [7:0] ob_sdo_bits = '0;
    logic       ob_prev_cs = 1'b1, ob_prev_sck = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            ob_prev_cs  = 1'b1;
            ob_prev_sck = 1'b0;
        end else begin
            if (ob_prev_cs && !cs_a) begin
                ob_prev_t0    = ob_t0;
                ob_t0         = cyc;
                ob_rises      = 0;
                ob_first_rise = 0;
                ob_rxv_c      = 0;
                ob_sdo_bits   = '0;
                ob_cs_low     = 0;
                ob_gap        = ob_high_run;
                ob_frames     = ob_frames + 1;
            end
            if (!cs_a) ob_cs_low = ob_cs_low + 1;
            ob_high_run = cs_a ? ob_high_run + 1 : 0;
            ob_c = cyc - ob_t0 + 1;
            if (sck_a && !ob_prev_sck) begin
                ob_rises = ob_rises + 1;
                if (ob_rises == 1) ob_first_rise = ob_c;
                ob_sdo_bits = {ob_sdo_bits[6:0], sdo_a};
            end
            if (rx_valid_a) ob_rxv_c = ob_c;
            ob_prev_cs  = cs_a;
            ob_prev_sck = sck_a;
        end
    end

    // Present a pixel to DUT A and hold it until the model has accepted it
    task automatic send_a(input logic [7:0] d);
        int n0;
        n0 = m_frames;
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        for (int i = 0; i < 200 && m_frames == n0; i++) @(negedge clk);
        tx_valid_a = 1'b0;
        chk("accept", m_frames - n0, 1);
    endtask

    int f0, n0, e0, got;

    initial begin
        rst = 1'b1;
        tx_data_a = '0; tx_valid_a = 1'b0;
        tx_data_b = '0; tx_valid_b = 1'b0;
        sdi_fixed = 1'b0; fixed_word = '0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_ready", tx_ready_a, 1);
        chk("rst_rx_data", rx_data_a, 0);
        chk("rst_rx_valid", rx_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_cs", cs_a, 1);
        chk("rst_sck", sck_a, 0);
        chk("rst_sdo", sdo_a, 0);
        chk("rst_b_ready", tx_ready_b, 1);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback 0xA5
        send_a(8'hA5);
        repeat (FRAME + 4) @(negedge clk);
        chk("lb_sdo_bits", ob_sdo_bits, 8'hA5);
        chk("lb_rxv_cycle", ob_rxv_c, 37);
        chk("lb_rx_data", rx_data_a, 8'hA5);
        chk("lb_cs_low", ob_cs_low, 36);
        chk("lb_rises", ob_rises, 8);

        // Target returns 0x3C while 0xFF is sent
        sdi_fixed = 1'b1; fixed_word = 8'h3C;
        send_a(8'hFF);
        repeat (FRAME + 4) @(negedge clk);
        chk("fix_rx_data", rx_data_a, 8'h3C);
        chk("fix_rises", ob_rises, 8);
        chk("fix_first_rise", ob_first_rise, 3);
        sdi_fixed = 1'b0;

        // Back-to-back with tx_valid held high
        n0 = m_frames;
        tx_data_a = 8'h01; tx_valid_a = 1'b1;
        for (int i = 0; i < 200 && m_frames == n0; i++) @(negedge clk);
        tx_data_a = 8'h80;
        for (int i = 0; i < 200 && m_frames == n0 + 1; i++) @(negedge clk);
        tx_valid_a = 1'b0;
        chk("b2b_accepts", m_frames - n0, 2);
        repeat (FRAME + 4) @(negedge clk);
        chk("b2b_spacing", ob_t0 - ob_prev_t0, 39);
        chk("b2b_gap", ob_gap, 3);
        chk("b2b_rx_data", rx_data_a, 8'h80);

        // Pulse while busy is ignored
        f0 = ob_frames;
        send_a(8'h33);
        repeat (9) @(negedge clk);
        chk("busy_ready_low", tx_ready_a, 0);
        tx_data_a = 8'h55; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (FRAME + 10) @(negedge clk);
        chk("busy_frames", ob_frames - f0, 1);
        chk("busy_rx_data", rx_data_a, 8'h33);

        // Reset in the middle of SHIFT
        send_a(8'hC3);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs", cs_a, 1);
        chk("mid_rst_sck", sck_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_rxv", rx_valid_a, 0);
        chk("mid_rst_rx_data", rx_data_a, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_a(8'h5A);
        repeat (FRAME + 4) @(negedge clk);
        chk("post_rst_rx_data", rx_data_a, 8'h5A);
        chk("post_rst_sdo_bits", ob_sdo_bits, 8'h5A);

        // DUT B: 24-bit loopback at CLK_DIV=1
        tx_data_b = 24'hABCDEF; tx_valid_b = 1'b1;
        @(negedge clk);
        e0 = cyc;
        tx_valid_b = 1'b0;
        got = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_valid_b) begin
                got = cyc - e0 + 1;
                break;
            end
        end
        chk("b_rxv_cycle", got, 51);
        chk("b_rx_data", rx_data_b, 24'hABCDEF);
        repeat (4) @(negedge clk);
        chk("b_idle_busy", busy_b, 0);
        chk("b_idle_cs", cs_b, 1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule

// File: doc/spi_px_master.md
# spi_px_master

SPI initiator that drives the pixel-processing chip's SPI target pins: CS, SCK and SDI, and reads back SDO. Each accepted input pixel is sent as one full-duplex SPI frame. The word shifted back in during that frame is returned as the result word. The block sits in the test/host-side FPGA wrapper and feeds grayscale/Sobel pixel streams into the chip's SPI port at a programmable SCK rate.

## Interface

Parameters:
- PX_BITS, default 24: bits per SPI frame (pixel width); legal values 2..32.
- CLK_DIV, default 4: number of clk_i cycles per SCK half-period; legal values ≥1.

Ports:
- clk_i, input, 1: single system clock.
- reset_i, input, 1: asynchronous, active-high reset.
- tx_data_i, input, PX_BITS: pixel to transmit, MSB first.
- tx_valid_i, input, 1: tx_data_i is valid.
- tx_ready_o, output, 1: block can accept a pixel; high only in IDLE.
- rx_data_o, output, PX_BITS: word captured from spi_sdi_i during the last frame; holds its value until the next frame completes.
- rx_valid_o, output, 1: one-cycle pulse when rx_data_o updates.
- busy_o, output, 1: high in every state except IDLE.
- spi_cs_o, output, 1: chip select, active-low, one frame per pixel.
- spi_sck_o, output, 1: SPI clock, mode 0 (idles low).
- spi_sdo_o, output, 1: serial data to the target's SDI.
- spi_sdi_i, input, 1: serial data from the target's SDO; asynchronous, sampled directly.

## Operation

- Reset values: tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, spi_cs_o=1, spi_sck_o=0, spi_sdo_o=0. All state registers clear, including the divider and bit counters.
- Accept: on a clk edge with tx_valid_i && tx_ready_o, load tx_data_i into the TX shift register and go to SETUP. tx_valid_i while busy is ignored; there is no queuing.
- FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- SETUP:
  - spi_cs_o=0 and spi_sdo_o=tx_data[PX_BITS-1].
  - Lasts CLK_DIV cycles, with SCK low.
- SHIFT: one divider counts CLK_DIV cycles per half-period, and spi_sck_o toggles at each terminal count.
  - Rising edge: the clk edge that drives spi_sck_o 0->1 also shifts spi_sdi_i into the LSB of the RX shift register.
  - Falling edge: the clk edge that drives spi_sck_o 1->0 shifts TX left and presents the next bit on spi_sdo_o. On the final (PX_BITS-th) falling edge, spi_sdo_o goes to 0 instead.
  - Exactly PX_BITS rising and PX_BITS falling edges occur per frame.
- HOLD: SCK low, CS still low, for CLK_DIV cycles.
- HOLD exit: the exiting edge sets spi_cs_o=1, loads rx_data_o from the RX shifter and pulses rx_valid_o.
- GAP: CS high for CLK_DIV cycles to meet the target's minimum deselect time. After GAP the FSM returns to IDLE and tx_ready_o=1.
- The bit counter is $clog2(PX_BITS+1) bits wide and counts rising edges. There is no wrap; the frame ends at count PX_BITS.
- rx_data_o is MSB-first: the first sampled bit ends up in bit PX_BITS-1.
- Reset mid-frame: all outputs return immediately (asynchronously) to reset values, CS deasserts and the partial RX word is discarded. No rx_valid_o pulse is issued for an aborted frame.

## Timing

- Accept edge = cycle 0.
- spi_cs_o falls at cycle 1.
- First SCK rise at cycle 1+CLK_DIV.
- Bit period is 2*CLK_DIV cycles, so the SCK frequency is f_clk/(2*CLK_DIV).
- rx_valid_o is high in cycle 1+(2*PX_BITS+2)*CLK_DIV, and spi_cs_o rises at the same edge.
- tx_ready_o is high again at cycle 1+(2*PX_BITS+3)*CLK_DIV.
- An accept in that same cycle starts the next frame; back-to-back throughput is one pixel per (2*PX_BITS+3)*CLK_DIV+1 cycles.
- spi_sdo_o changes only on SCK falling edges or at frame start, so it is stable ≥CLK_DIV cycles before each SCK rise.
- All outputs are registered with no combinational path from inputs to outputs. tx_ready_o is decoded from the state register.

## Test plan

Use PX_BITS=8 and CLK_DIV=2 unless noted.

- **Reset mid-frame:** assert reset_i at any cycle during SHIFT -> in the same cycle spi_cs_o=1, spi_sck_o=0 and busy_o=0; no rx_valid_o pulse; the next frame transmits correctly.
- **Loopback:** tie spi_sdi_i=spi_sdo_o and send 0xA5 -> the SDO bit sequence sampled on SCK rises is 1,0,1,0,0,1,0,1; rx_valid_o pulses at cycle 37; rx_data_o=0xA5; spi_cs_o is low cycles 1..36.
- **Target model returning a fixed word:** the model returns 0x3C while the block sends 0xFF -> rx_data_o=0x3C; exactly 8 SCK rising edges; first rise at cycle 3.
- **Back-to-back:** hold tx_valid_i high with 0x01, then 0x80 -> the second accept occurs at cycle 39; CS stays high for ≥2 cycles between frames; rx words match the model.
- **Busy ignore:** pulse tx_valid_i with 0x55 at cycle 10 of a frame -> tx_ready_o=0, the pulse is ignored and no extra frame is sent.
- **CLK_DIV=1 with PX_BITS=24:** send 0xABCDEF in loopback -> rx_valid_o at cycle 51 and rx_data_o=0xABCDEF.
